// File: rtl/sound_arbiter.sv
// Shares the single tone path among the key, land, row and lose sound sources.
// Rising request edges queue as pending flags; one two-note effect plays at a time with strict preemption.
module sound_arbiter #(
  parameter int          KEY_LEN  = 2**20,
  parameter int          LAND_LEN = 2**22,
  parameter int          ROW_LEN  = 2**23,
  parameter int          LOSE_LEN = 2**23,
  parameter int          GAP_LEN  = 1024,
  parameter logic [19:0] F0A = 20'd50000,
  parameter logic [19:0] F0B = 20'd40000,
  parameter logic [19:0] F1A = 20'd60000,
  parameter logic [19:0] F1B = 20'd70000,
  parameter logic [19:0] F2A = 20'd30000,
  parameter logic [19:0] F2B = 20'd25000,
  parameter logic [19:0] F3A = 20'd90000,
  parameter logic [19:0] F3B = 20'd120000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic        write_ready,
  input  logic        mute,
  output logic [19:0] freq,
  output logic        write_en,
  output logic [1:0]  active_id,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  // Last count and half-point per source, precomputed at 24 bits so a length of 2**24 still works.
  localparam logic [23:0] KEY_LAST  = 24'(KEY_LEN - 1);
  localparam logic [23:0] LAND_LAST = 24'(LAND_LEN - 1);
  localparam logic [23:0] ROW_LAST  = 24'(ROW_LEN - 1);
  localparam logic [23:0] LOSE_LAST = 24'(LOSE_LEN - 1);
  localparam logic [23:0] KEY_HALF  = 24'(KEY_LEN / 2);
  localparam logic [23:0] LAND_HALF = 24'(LAND_LEN / 2);
  localparam logic [23:0] ROW_HALF  = 24'(ROW_LEN / 2);
  localparam logic [23:0] LOSE_HALF = 24'(LOSE_LEN / 2);
  localparam logic [23:0] GAP_LAST  = 24'(GAP_LEN - 1);

  state_t      state, state_nx;
  logic [3:0]  pend, pend_nx, pend_clr, req_d, above;
  logic [23:0] cnt, cnt_nx, cur_last, cur_half;
  logic [1:0]  id_nx;
  logic [19:0] tone_a, tone_b;

  function automatic logic [1:0] top_idx(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  always_comb begin
    unique case (active_id)
      2'd0: begin cur_last = KEY_LAST;  cur_half = KEY_HALF;  tone_a = F0A; tone_b = F0B; end
      2'd1: begin cur_last = LAND_LAST; cur_half = LAND_HALF; tone_a = F1A; tone_b = F1B; end
      2'd2: begin cur_last = ROW_LAST;  cur_half = ROW_HALF;  tone_a = F2A; tone_b = F2B; end
      default: begin cur_last = LOSE_LAST; cur_half = LOSE_HALF; tone_a = F3A; tone_b = F3B; end
    endcase
  end

  // Only sources strictly above the one playing may cut in.
  assign above = pend & (4'b1110 << active_id);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_nx = state;
    cnt_nx   = cnt;
    id_nx    = active_id;
    pend_clr = '0;
    unique case (state)
      IDLE: begin
        if (|pend) begin
          state_nx = PLAY;
          id_nx    = top_idx(pend);
          cnt_nx   = '0;
          pend_clr = 4'b0001 << top_idx(pend);
        end
      end
      PLAY: begin
        if (|above) begin
          id_nx    = top_idx(above);
          cnt_nx   = '0;
          pend_clr = 4'b0001 << top_idx(above);
        end else if (cnt == cur_last) begin
          state_nx = GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 24'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 24'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    // A new edge on the granted source at the same edge re-queues it.
    pend_nx = (pend & ~pend_clr) | (req & ~req_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state     <= IDLE;
      pend      <= '0;
      req_d     <= '0;
      cnt       <= '0;
      active_id <= '0;
    end else begin
      state     <= state_nx;
      pend      <= pend_nx;
      req_d     <= req;
      cnt       <= cnt_nx;
      active_id <= id_nx;
    end
  end

  always_comb begin
    freq = '0;
    if (state == PLAY) freq = (cnt < cur_half) ? tone_a : tone_b;
  end

  assign write_en = (state == PLAY) & write_ready & ~mute;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter: single effect, preemption, queueing, held/retriggered
// requests, reset mid-effect and codec strobe gating.
module tb_sound_arbiter;

  logic        clk = 1'b0;
  logic        reset, write_ready, mute;
  logic [3:0]  req;
  logic [19:0] freq;
  logic        write_en, busy;
  logic [1:0]  active_id;

  int checks   = 0;
  int failures = 0;

  localparam int LENS [4] = '{8, 12, 16, 20};

  always #5 clk = ~clk;

  sound_arbiter #(
    .KEY_LEN(8), .LAND_LEN(12), .ROW_LEN(16), .LOSE_LEN(20), .GAP_LEN(2),
    .F0A(20'd100), .F0B(20'd200), .F1A(20'd101), .F1B(20'd201),
    .F2A(20'd102), .F2B(20'd202), .F3A(20'd103), .F3B(20'd203)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .write_ready(write_ready), .mute(mute),
    .freq(freq), .write_en(write_en), .active_id(active_id), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] tone(input int id, input int k);
    return (k < LENS[id] / 2) ? 20'(100 + id) : 20'(200 + id);
  endfunction

  // First step is the grant edge; optionally pulses pulse_v on req before step pulse_k.
  task automatic play(input string tag, input int id, input int pulse_k, input logic [3:0] pulse_v);
    for (int k = 0; k < LENS[id]; k++) begin
      if (k == pulse_k) req = pulse_v;
      else if (k == pulse_k + 1) req = '0;
      step();
      check({tag, "_freq"}, 32'(freq), 32'(tone(id, k)));
      check({tag, "_id"}, 32'(active_id), 32'(id));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_we"}, 32'(write_en), 32'd1);
    end
  endtask

  task automatic gap_idle(input string tag);
    for (int k = 0; k < 2; k++) begin
      step();
      check({tag, "_gap_freq"}, 32'(freq), 32'd0);
      check({tag, "_gap_busy"}, 32'(busy), 32'd1);
      check({tag, "_gap_we"}, 32'(write_en), 32'd0);
    end
    step();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_freq"}, 32'(freq), 32'd0);
  endtask

  initial begin
    reset = 1'b0; req = '0; write_ready = 1'b1; mute = 1'b0;
    step();
    step();
    check("rst_freq", 32'(freq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(write_en), 32'd0);
    check("rst_id", 32'(active_id), 32'd0);
    reset = 1'b1;
    step();

    // Single key: pulse sampled at edge 0, plays edges 1..8, gap 9..10, idle at 11.
    req = 4'b0001; step(); req = '0;
    play("key", 0, -5, '0);
    gap_idle("key");

    // Preemption: land granted at edge 1, lose request sampled at edge 6, lose at edge 7.
    req = 4'b0010; step(); req = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("land_freq", 32'(freq), 32'(tone(1, k)));
      check("land_id", 32'(active_id), 32'd1);
    end
    req = 4'b1000; step();
    check("land_pre_freq", 32'(freq), 32'd101);
    req = '0;
    play("lose", 3, -5, '0);
    gap_idle("lose");
    for (int k = 0; k < 3; k++) begin
      step();
      check("land_dropped", 32'(busy), 32'd0);
    end

    // Queueing: row then key after the gap.
    req = 4'b0101; step(); req = '0;
    play("q_row", 2, -5, '0);
    gap_idle("q_row");
    play("q_key", 0, -5, '0);
    gap_idle("q_key");

    // Held level: exactly one lose effect across ~100 cycles.
    req = 4'b1000; step();
    play("held", 3, -5, '0);
    gap_idle("held");
    for (int k = 0; k < 77; k++) begin
      step();
      check("held_once", 32'(busy), 32'd0);
    end
    req = '0; step();

    // Retrigger during key effect replays after the gap.
    req = 4'b0001; step(); req = '0;
    play("retrig1", 0, 3, 4'b0001);
    gap_idle("retrig1");
    play("retrig2", 0, -5, '0);
    gap_idle("retrig2");

    // Reset mid-row with a key request pending.
    req = 4'b0101; step(); req = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rrow_freq", 32'(freq), 32'(tone(2, k)));
    end
    reset = 1'b0; step();
    check("mid_rst_freq", 32'(freq), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_we", 32'(write_en), 32'd0);
    check("mid_rst_id", 32'(active_id), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("pend_lost", 32'(busy), 32'd0);
    end

    // Backpressure then mute during a key effect.
    req = 4'b0001; step(); req = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("bp_freq", 32'(freq), 32'(tone(0, k)));
      check("bp_busy", 32'(busy), 32'd1);
      write_ready = (k % 2 == 1);
      mute = (k >= 4);
      #1;
      check("bp_we", 32'(write_en), (k < 4) ? 32'(k % 2) : 32'd0);
    end
    write_ready = 1'b1; mute = 1'b0;
    gap_idle("bp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sound_arbiter.md
# sound_arbiter

Schedules the single audio tone path (square-wave generator feeding the audio codec) among the four game sound sources: key press, block landed, row scored and game lost. It replaces the per-source sound_effects timers and the fixed priority freq mux in DE1_SoC. It edge-detects requests, queues them as pending flags, and plays one two-note effect at a time with strict priority preemption. It drives `freq` and the codec `write` strobe.

## Interface
- `KEY_LEN`, 2**20: cycles the key-press effect lasts (≥2, ≤2**24)
- `LAND_LEN`, 2**22: cycles for the block-landed effect
- `ROW_LEN`, 2**23: cycles for the row-scored effect
- `LOSE_LEN`, 2**23: cycles for the game-lost effect
- `GAP_LEN`, 1024: silent cycles between consecutive effects (≥1)
- `F0A`/`F0B`, `F1A`/`F1B`, `F2A`/`F2B`, `F3A`/`F3B`, 20-bit: first-half and second-half tone for sources 0..3 (0=key, 1=land, 2=row, 3=lose)
- `clk` in 1: system clock (CLOCK_50)
- `reset` in 1: synchronous, active-low reset
- `req` in 4: level request per source; bit 3 = lose (highest priority), bit 0 = key (lowest)
- `write_ready` in 1: codec can accept a sample
- `mute` in 1: suppress codec writes without stopping sequencing
- `freq` out 20: tone to square_wave; 0 when silent
- `write_en` out 1: codec write strobe
- `active_id` out 2: source currently playing
- `busy` out 1: high in PLAY or GAP

## Operation
- Edge detect: `req_d` registers `req`. `pend[i]` is set at any edge where `req[i] & ~req_d[i]`. A held level therefore gives one request.
- Setting `pend[i]` when it is already set has no effect. Requests do not count up.
- If a set and a clear of `pend[i]` occur at the same edge, the set wins.
- State machine has three states: IDLE, PLAY, GAP.
- IDLE: if any `pend` bit is set, go to PLAY at the next edge. The winner is the highest set index `w`. Clear `pend[w]`, set `active_id`=`w`, `cnt`=0, `freq`=`FwA`. With no pending bits, stay in IDLE with `freq`=0.
- PLAY: `cnt` increments every cycle.
  - `freq`=`FwA` while `cnt` < `LEN_w`/2 (integer divide). Otherwise `freq`=`FwB`.
  - At `cnt`==`LEN_w`-1, the next edge goes to GAP with `cnt`=0 and `freq`=0.
- Preemption: in PLAY, if any `pend[j]` is set with `j` > `active_id`, the next edge reloads exactly as the IDLE grant does, using the highest such `j`. There is no gap. The preempted effect is dropped and never resumed. Preemption has priority over end-of-effect at the same edge.
- A pending bit equal to or below `active_id` waits. A retrigger of the active source therefore replays after the gap.
- GAP: `freq`=0 and `cnt` counts. At `cnt`==`GAP_LEN`-1, go to IDLE. Pending bits are not granted during GAP, even lose.
- `write_en` = (state==PLAY) & `write_ready` & ~`mute`. This is combinational from registered state and the input. No other output depends combinationally on any input.
- `busy` = state != IDLE.
- `cnt` is 24 bits. Length comparisons are done at 24 bits. LEN and GAP parameters out of range are a configuration error and are not checked.

## Timing
- Reset values: state=IDLE, `pend`=0, `req_d`=0, `cnt`=0, `freq`=0, `active_id`=0, `busy`=0, `write_en`=0.
- Reset asserted mid-effect aborts it at that edge. All pending requests are lost.
- Latency is 2 edges from `req` rising to `freq` valid: edge N sets `pend`, edge N+1 grants. This applies when the arbiter is IDLE.
- An effect occupies exactly `LEN_w` cycles in PLAY, then `GAP_LEN` cycles in GAP.
- Preemption takes effect 2 edges after the higher-priority `req` rises.
- `write_ready` low only stalls the strobe. Effect timing is unaffected.

## Test plan
Bench overrides: `KEY_LEN`=8, `LAND_LEN`=12, `ROW_LEN`=16, `LOSE_LEN`=20, `GAP_LEN`=2, `FiA`=100+i, `FiB`=200+i, `write_ready`=1, `mute`=0.

- **Single key:** `req[0]` is a 1-cycle pulse at edge 0. Required response:
  - `freq`=100 for edges 1..4, then 200 for edges 5..8.
  - `freq`=0 and `busy`=1 for 2 cycles.
  - `busy`=0 from edge 11.
  - `write_en` high for exactly 8 cycles.
- **Preemption:** `req[1]` pulses, then `req[3]` rises 5 cycles into the land effect. Required response:
  - `active_id`=3 and `freq`=103 two edges later.
  - The lose effect runs its full 20 cycles and land never resumes.
- **Queueing:** `req[2]` and `req[0]` rise on the same cycle. Required response:
  - Row plays 16 cycles, then a 2-cycle gap.
  - Key plays 8 cycles, starting at `freq`=100.
- **Held level and retrigger:** `req[3]` held high for 100 cycles gives exactly one lose effect. A second `req[0]` pulse during the key effect gives two key effects separated by the gap.
- **Reset mid-play:** `reset`=0 at cycle 6 of the row effect. On the next edge all outputs are at reset values. Pending `req[0]` queued before the reset is never played.
- **Mute and backpressure:** toggle `write_ready` every cycle, then hold `mute`=1, during a key effect. Required response:
  - `write_en` follows `write_ready`, and is always 0 while muted.
  - `freq` sequence and 8-cycle duration are unchanged.
